// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-RAM interface, one request in flight
//
// Accepts a single load/store from the core, checks size/range (and alignment when
// MISALIGN_TRAP_EN is defined), performs one RAM access cycle, extracts/extends the
// big-endian load data and returns one response.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   -> misaligned half/word requests return resp_err with no RAM access
//   undefined -> misaligned requests proceed as byte-addressed big-endian accesses
//
// Ports
//   CLK, reset                     clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned store flag, size (00 B, 01 H, 10 W, 11 reserved), zero-extend flag
//   req_addr, req_wdata            byte address, store data (low bytes for B/H)
//   resp_valid/resp_ready          response handshake
//   resp_data, resp_err            extended load data (0 for stores/errors), error flag
//   addr, write_data               RAM address and store data, driven only during the access cycle
//   memread, memwrite, storeops    RAM strobes and store width
//   read_data                      combinational RAM read {ram[a],ram[a+1],ram[a+2],ram[a+3]}
`ifndef STORE_B
`define STORE_B 2'b01
`endif
`ifndef STORE_H
`define STORE_H 2'b10
`endif
`ifndef STORE_W
`define STORE_W 2'b11
`endif

module load_store_unit #(
  parameter int ADDR_LIMIT = 1024
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] addr,
  output logic [31:0] write_data,
  output logic        memread,
  output logic        memwrite,
  output logic [1:0]  storeops,
  input  logic [31:0] read_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, data_q, load_data;
  logic [32:0] nbytes, end_addr;
  logic        range_err, mis_err, req_err, acc;
  // 33-bit end address so that a request wrapping past 2^32 is also out of range
  assign nbytes    = req_size == 2'b00 ? 33'd1 : req_size == 2'b01 ? 33'd2 : 33'd4;
  assign end_addr  = {1'b0, req_addr} + nbytes;
  assign range_err = end_addr > 33'(ADDR_LIMIT);
`ifdef MISALIGN_TRAP_EN
  assign mis_err = (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
  assign mis_err = 1'b0;
`endif
  assign req_err = req_size == 2'b11 || range_err || mis_err;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_valid ? (req_err ? RESP : ACCESS) : IDLE;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = resp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // The addressed byte is always the most significant lane of read_data
  always_comb begin
    load_data = read_data;
    load_data = size_q == 2'b00 ? {{24{~uns_q & read_data[31]}}, read_data[31:24]} :
                size_q == 2'b01 ? {{16{~uns_q & read_data[31]}}, read_data[31:16]} : read_data;
  end
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_err;
        data_q  <= '0;
      end
      if (state == ACCESS && !we_q) data_q <= load_data;
    end
  end
  // Gating with reset keeps the strobes low the instant reset asserts mid-access
  assign acc        = state == ACCESS && reset;
  assign addr       = acc ? addr_q : '0;
  assign write_data = acc && we_q ? wdata_q : '0;
  assign memread    = acc && !we_q;
  assign memwrite   = acc && we_q;
  assign storeops   = !(acc && we_q) ? 2'b00 : size_q == 2'b00 ? `STORE_B : size_q == 2'b01 ? `STORE_H : `STORE_W;
  assign req_ready  = state == IDLE && reset;
  assign resp_valid = state == RESP;
  assign resp_data  = resp_valid ? data_q : '0;
  assign resp_err   = resp_valid && err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed table-driven checks of load_store_unit against a byte RAM model
`ifndef STORE_B
`define STORE_B 2'b01
`endif
`ifndef STORE_H
`define STORE_H 2'b10
`endif
`ifndef STORE_W
`define STORE_W 2'b11
`endif

module tb_load_store_unit;
  logic        CLK = 1'b0, reset = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, memread, memwrite;
  logic [31:0] resp_data, addr, write_data, read_data;
  logic [1:0]  storeops;
  logic [7:0]  ram [0:1023];
  int          tests = 0, fails = 0;
  int          mr_cnt = 0, mw_cnt = 0;
  logic [1:0]  ops_seen = 2'b00;

  load_store_unit #(.ADDR_LIMIT(1024)) dut (
    .CLK(CLK), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .addr(addr), .write_data(write_data), .memread(memread), .memwrite(memwrite),
    .storeops(storeops), .read_data(read_data)
  );

  always #5 CLK = ~CLK;

  // Big-endian byte RAM: written on the clock edge, read combinationally
  always_comb read_data = {ram[addr[9:0]], ram[10'(addr[9:0] + 10'd1)], ram[10'(addr[9:0] + 10'd2)], ram[10'(addr[9:0] + 10'd3)]};
  always @(posedge CLK)
    if (memwrite)
      case (storeops)
        `STORE_B: ram[addr[9:0]] <= write_data[7:0];
        `STORE_H: begin ram[addr[9:0]] <= write_data[15:8]; ram[10'(addr[9:0] + 10'd1)] <= write_data[7:0]; end
        `STORE_W: begin
          ram[addr[9:0]] <= write_data[31:24];
          ram[10'(addr[9:0] + 10'd1)] <= write_data[23:16];
          ram[10'(addr[9:0] + 10'd2)] <= write_data[15:8];
          ram[10'(addr[9:0] + 10'd3)] <= write_data[7:0];
        end
        default: ;
      endcase

  always @(negedge CLK) begin
    if (memread) mr_cnt++;
    if (memwrite) begin mw_cnt++; ops_seen = storeops; end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] data;
    logic        err;
    logic [1:0]  ops;
  } vec_t;

  vec_t vecs [0:19];
  int   nvec;

  function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] data, logic err, logic [1:0] ops);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.a = a; v.wd = wd; v.data = data; v.err = err; v.ops = ops;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!req_ready && n < 20) begin @(negedge CLK); n++; end
    chk({name, " ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int lat;
    string nm;
    nm = $sformatf("v%0d", i);
    wait_ready(nm);
    mr_cnt = 0; mw_cnt = 0; ops_seen = 2'b00;
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.a; req_wdata = v.wd;
    @(negedge CLK);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin @(negedge CLK); lat++; end
    chk({nm, " data"}, resp_data, v.data);
    chk({nm, " err"}, 32'(resp_err), 32'(v.err));
    chk({nm, " latency"}, 32'(lat), v.err ? 32'd1 : 32'd2);
    chk({nm, " memread cycles"}, 32'(mr_cnt), (!v.err && !v.we) ? 32'd1 : 32'd0);
    chk({nm, " memwrite cycles"}, 32'(mw_cnt), (!v.err && v.we) ? 32'd1 : 32'd0);
    chk({nm, " storeops"}, 32'(ops_seen), 32'(v.ops));
    resp_ready = 1'b1;
    @(negedge CLK);
    resp_ready = 1'b0;
    chk({nm, " resp_valid drop"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] held;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    nvec = 0;
    vecs[nvec++] = mk(1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0, `STORE_W);
    vecs[nvec++] = mk(0, 2'b10, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2'b00);
    vecs[nvec++] = mk(0, 2'b00, 0, 32'h11,  32'h0,        32'hFFFFFFAD, 0, 2'b00);
    vecs[nvec++] = mk(0, 2'b00, 1, 32'h11,  32'h0,        32'h000000AD, 0, 2'b00);
    vecs[nvec++] = mk(0, 2'b01, 0, 32'h12,  32'h0,        32'hFFFFBEEF, 0, 2'b00);
    vecs[nvec++] = mk(0, 2'b01, 1, 32'h12,  32'h0,        32'h0000BEEF, 0, 2'b00);
    vecs[nvec++] = mk(0, 2'b10, 1, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2'b00);
`ifdef MISALIGN_TRAP_EN
    vecs[nvec++] = mk(0, 2'b01, 0, 32'h13,  32'h0,        32'h0,        1, 2'b00);
    vecs[nvec++] = mk(0, 2'b10, 0, 32'h11,  32'h0,        32'h0,        1, 2'b00);
`else
    vecs[nvec++] = mk(0, 2'b01, 0, 32'h13,  32'h0,        32'hFFFFEF00, 0, 2'b00);
    vecs[nvec++] = mk(0, 2'b10, 0, 32'h11,  32'h0,        32'hADBEEF00, 0, 2'b00);
`endif
    vecs[nvec++] = mk(0, 2'b10, 0, 32'h3FE, 32'h0,        32'h0,        1, 2'b00);
    vecs[nvec++] = mk(0, 2'b11, 0, 32'h20,  32'h0,        32'h0,        1, 2'b00);
    vecs[nvec++] = mk(1, 2'b00, 0, 32'h20,  32'h123456A5, 32'h0,        0, `STORE_B);
    vecs[nvec++] = mk(1, 2'b01, 0, 32'h22,  32'h55557F81, 32'h0,        0, `STORE_H);
    vecs[nvec++] = mk(0, 2'b10, 0, 32'h20,  32'h0,        32'hA5007F81, 0, 2'b00);
    vecs[nvec++] = mk(1, 2'b10, 0, 32'h3FC, 32'h0102FF80, 32'h0,        0, `STORE_W);
    vecs[nvec++] = mk(0, 2'b00, 0, 32'h3FF, 32'h0,        32'hFFFFFF80, 0, 2'b00);
    vecs[nvec++] = mk(0, 2'b10, 0, 32'h3FC, 32'h0,        32'h0102FF80, 0, 2'b00);
    vecs[nvec++] = mk(0, 2'b01, 0, 32'h3FF, 32'h0,        32'h0,        1, 2'b00);
    vecs[nvec++] = mk(0, 2'b10, 0, 32'hFFFFFFFC, 32'h0,   32'h0,        1, 2'b00);
    vecs[nvec++] = mk(1, 2'b10, 0, 32'h3FE, 32'h11111111, 32'h0,        1, 2'b00);

    repeat (2) @(negedge CLK);
    chk("in-reset req_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    @(negedge CLK);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset strobes", {30'd0, memread, memwrite}, 32'd0);
    chk("reset addr", addr, 32'd0);
    chk("reset storeops", 32'(storeops), 32'd0);

    for (int i = 0; i < nvec; i++) run_vec(i, vecs[i]);

    // Back-pressure: response must hold while a second request is presented
    wait_ready("hold");
    mw_cnt = 0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
    @(negedge CLK);
    req_we = 1'b1; req_wdata = 32'h0BADF00D;
    n = 0;
    while (!resp_valid && n < 10) begin @(negedge CLK); n++; end
    held = 32'hDEADBEEF;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d resp_valid", k), 32'(resp_valid), 32'd1);
      chk($sformatf("hold%0d resp_data", k), resp_data, held);
      chk($sformatf("hold%0d req_ready", k), 32'(req_ready), 32'd0);
      @(negedge CLK);
    end
    resp_ready = 1'b1; req_valid = 1'b0;
    @(negedge CLK);
    resp_ready = 1'b0;
    chk("hold no store accepted", 32'(mw_cnt), 32'd0);
    chk("hold back to idle", 32'(req_ready), 32'd1);
    chk("hold ram intact", {ram[16], ram[17], ram[18], ram[19]}, 32'hDEADBEEF);

    // Reset asserted in the middle of a store access
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
    @(negedge CLK);
    req_valid = 1'b0;
    chk("rst-acc memwrite before", 32'(memwrite), 32'd1);
    #2 reset = 1'b0;
    #1 chk("rst-acc memwrite drops", 32'(memwrite), 32'd0);
    chk("rst-acc resp_valid", 32'(resp_valid), 32'd0);
    @(negedge CLK);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk($sformatf("rst-rel%0d resp_valid", k), 32'(resp_valid), 32'd0);
      chk($sformatf("rst-rel%0d req_ready", k), 32'(req_ready), 32'd1);
    end
    run_vec(99, mk(0, 2'b10, 0, 32'h30, 32'h0, 32'h0, 0, 2'b00));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
